// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU/memory op codes, EX/MEM record.
// Also the mul/div FSM state type and the helper that flags multi-cycle ops.
package ex_stage_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned MEM_OP_W   = 2;

    localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = '0;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MUL  = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_OP_DIV  = 4'd11;
    localparam logic [ALU_OP_W-1:0] ALU_OP_DIVU = 4'd12;
    localparam logic [ALU_OP_W-1:0] ALU_OP_REM  = 4'd13;
    localparam logic [ALU_OP_W-1:0] ALU_OP_REMU = 4'd14;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP  = 4'd15;

    typedef enum logic [1:0] {
        MdIdle,
        MdRun,
        MdDone
    } md_state_e;

    typedef struct packed {
        logic                  en;
        logic [MEM_OP_W-1:0]   mem_op;
        logic [WORD_W-1:0]     wr_data;
        logic [REG_ADDR_W-1:0] dst;
        logic                  gpr_we_;
        logic [WORD_W-1:0]     out;
    } ex_mem_t;

    localparam ex_mem_t EX_MEM_BUBBLE = '{
        en:      1'b0,
        mem_op:  MEM_OP_NOP,
        wr_data: '0,
        dst:     '0,
        gpr_we_: 1'b1,
        out:     '0
    };

    function automatic logic is_md_op(input logic [ALU_OP_W-1:0] op);
        return (op >= ALU_OP_MUL) && (op <= ALU_OP_REMU);
    endfunction

endpackage

// File: rtl/ex_stage_mul_div.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Operands are latched on start; the result is presented while the FSM sits in DONE.
module mul_div
    import ex_stage_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WORD_W-1:0]   a,
    input  logic [WORD_W-1:0]   b,
    input  logic                stall,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [WORD_W-1:0]   result
);

    localparam int unsigned CntW = $clog2(MD_CYCLES);

    md_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ALU_OP_W-1:0]   op_q, op_d;
    // acc: product / partial remainder; opa: multiplicand / divisor;
    // opb: multiplier / dividend shifting into quotient.
    logic [WORD_W-1:0]     acc_q, acc_d;
    logic [WORD_W-1:0]     opa_q, opa_d;
    logic [WORD_W-1:0]     opb_q, opb_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;

    logic                  last_step;
    logic                  is_signed;
    logic                  a_neg, b_neg;
    logic [WORD_W-1:0]     a_mag, b_mag;
    logic [WORD_W:0]       rem_sh;
    logic [WORD_W-1:0]     rem_diff;
    logic                  rem_ge;
    logic [WORD_W-1:0]     quo_fix, rem_fix;

    assign last_step = (cnt_q == CntW'(MD_CYCLES - 1));
    assign is_signed = (op == ALU_OP_DIV) || (op == ALU_OP_REM);
    assign a_neg     = is_signed & a[WORD_W-1];
    assign b_neg     = is_signed & b[WORD_W-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // rem_sh < 2*divisor when rem_ge, so the 32-bit difference is exact.
    assign rem_sh   = {acc_q, opb_q[WORD_W-1]};
    assign rem_ge   = (rem_sh >= {1'b0, opa_q});
    assign rem_diff = rem_sh[WORD_W-1:0] - opa_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;

        case (state_q)
            MdIdle: begin
                if (start && !stall && !flush) begin
                    state_d = MdRun;
                    cnt_d   = '0;
                    op_d    = op;
                    acc_d   = '0;
                    if (op == ALU_OP_MUL) begin
                        opa_d   = a;
                        opb_d   = b;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                    end else begin
                        opa_d   = b_mag;
                        opb_d   = a_mag;
                        // Divide by zero leaves an all-ones quotient, so keep it unsigned.
                        q_neg_d = (a_neg ^ b_neg) && (b != '0);
                        r_neg_d = a_neg;
                    end
                end
            end
            MdRun: begin
                if (flush) begin
                    state_d = MdIdle;
                    cnt_d   = '0;
                end else if (!stall) begin
                    if (op_q == ALU_OP_MUL) begin
                        acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                    end else begin
                        acc_d = rem_ge ? rem_diff : rem_sh[WORD_W-1:0];
                        opb_d = {opb_q[WORD_W-2:0], rem_ge};
                    end
                    if (last_step) begin
                        state_d = MdDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            MdDone: begin
                if (flush || !stall) begin
                    state_d = MdIdle;
                end
            end
            default: state_d = MdIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            op_q    <= ALU_OP_NOP;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    assign quo_fix = q_neg_q ? -opb_q : opb_q;
    assign rem_fix = r_neg_q ? -acc_q : acc_q;

    always_comb begin
        result = acc_q;
        case (op_q)
            ALU_OP_DIV, ALU_OP_DIVU: result = quo_fix;
            ALU_OP_REM, ALU_OP_REMU: result = rem_fix;
            default:                 result = acc_q;
        endcase
    end

    assign busy = ((state_q == MdIdle) && start) || (state_q == MdRun);
    assign done = (state_q == MdDone);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, iterative mul/div, and the EX/MEM pipeline register.
// While the mul/div unit works the stage requests a hold upstream and emits bubbles.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_en,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [WORD_W-1:0]     id_alu_in_0,
    input  logic [WORD_W-1:0]     id_alu_in_1,
    input  logic [MEM_OP_W-1:0]   id_mem_op,
    input  logic [WORD_W-1:0]     id_mem_wr_data,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_gpr_we_,
    output logic                  ex_busy,
    output logic                  ex_en,
    output logic [MEM_OP_W-1:0]   ex_mem_op,
    output logic [WORD_W-1:0]     ex_mem_wr_data,
    output logic [REG_ADDR_W-1:0] ex_dst_addr,
    output logic                  ex_gpr_we_,
    output logic [WORD_W-1:0]     ex_out
);

    logic [WORD_W-1:0] alu_res;
    logic [4:0]        shamt;
    logic              md_start;
    logic              md_busy;
    logic              md_done;
    logic [WORD_W-1:0] md_result;
    ex_mem_t           ex_mem_q, ex_mem_d;

    assign shamt    = id_alu_in_1[4:0];
    assign md_start = id_en && is_md_op(id_alu_op);

    always_comb begin
        alu_res = '0;
        case (id_alu_op)
            ALU_OP_ADD:  alu_res = id_alu_in_0 + id_alu_in_1;
            ALU_OP_SUB:  alu_res = id_alu_in_0 - id_alu_in_1;
            ALU_OP_AND:  alu_res = id_alu_in_0 & id_alu_in_1;
            ALU_OP_OR:   alu_res = id_alu_in_0 | id_alu_in_1;
            ALU_OP_XOR:  alu_res = id_alu_in_0 ^ id_alu_in_1;
            ALU_OP_SLL:  alu_res = id_alu_in_0 << shamt;
            ALU_OP_SRL:  alu_res = id_alu_in_0 >> shamt;
            ALU_OP_SRA:  alu_res = $signed(id_alu_in_0) >>> shamt;
            ALU_OP_SLT:  alu_res = {{(WORD_W-1){1'b0}},
                                    ($signed(id_alu_in_0) < $signed(id_alu_in_1))};
            ALU_OP_SLTU: alu_res = {{(WORD_W-1){1'b0}}, (id_alu_in_0 < id_alu_in_1)};
            ALU_OP_NOP:  alu_res = id_alu_in_0;
            default:     alu_res = '0;
        endcase
    end

    mul_div #(
        .MD_CYCLES(MD_CYCLES)
    ) u_mul_div (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (id_alu_op),
        .a      (id_alu_in_0),
        .b      (id_alu_in_1),
        .stall  (stall),
        .flush  (flush),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign ex_busy = md_busy;

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (flush) begin
            ex_mem_d = EX_MEM_BUBBLE;
        end else if (stall) begin
            ex_mem_d = ex_mem_q;
        end else if (ex_busy) begin
            ex_mem_d = EX_MEM_BUBBLE;
        end else begin
            ex_mem_d.en      = id_en;
            ex_mem_d.mem_op  = id_mem_op;
            ex_mem_d.wr_data = id_mem_wr_data;
            ex_mem_d.dst     = id_dst_addr;
            ex_mem_d.gpr_we_ = id_gpr_we_;
            ex_mem_d.out     = md_done ? md_result : alu_res;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_q <= EX_MEM_BUBBLE;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign ex_en          = ex_mem_q.en;
    assign ex_mem_op      = ex_mem_q.mem_op;
    assign ex_mem_wr_data = ex_mem_q.wr_data;
    assign ex_dst_addr    = ex_mem_q.dst;
    assign ex_gpr_we_     = ex_mem_q.gpr_we_;
    assign ex_out         = ex_mem_q.out;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a vector table of ALU and mul/div ops with hand-computed
// results, followed by sequences for stall, flush, stall+flush and asynchronous reset.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  stall;
    logic                  flush;
    logic                  id_en;
    logic [ALU_OP_W-1:0]   id_alu_op;
    logic [WORD_W-1:0]     id_alu_in_0;
    logic [WORD_W-1:0]     id_alu_in_1;
    logic [MEM_OP_W-1:0]   id_mem_op;
    logic [WORD_W-1:0]     id_mem_wr_data;
    logic [REG_ADDR_W-1:0] id_dst_addr;
    logic                  id_gpr_we_;
    logic                  ex_busy;
    logic                  ex_en;
    logic [MEM_OP_W-1:0]   ex_mem_op;
    logic [WORD_W-1:0]     ex_mem_wr_data;
    logic [REG_ADDR_W-1:0] ex_dst_addr;
    logic                  ex_gpr_we_;
    logic [WORD_W-1:0]     ex_out;

    ex_stage #(
        .MD_CYCLES(32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .id_en          (id_en),
        .id_alu_op      (id_alu_op),
        .id_alu_in_0    (id_alu_in_0),
        .id_alu_in_1    (id_alu_in_1),
        .id_mem_op      (id_mem_op),
        .id_mem_wr_data (id_mem_wr_data),
        .id_dst_addr    (id_dst_addr),
        .id_gpr_we_     (id_gpr_we_),
        .ex_busy        (ex_busy),
        .ex_en          (ex_en),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_out         (ex_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int tag);
        id_en          = 1'b1;
        id_alu_op      = op;
        id_alu_in_0    = a;
        id_alu_in_1    = b;
        id_mem_op      = tag[1:0];
        id_mem_wr_data = 32'(tag * 3);
        id_dst_addr    = tag[4:0];
        id_gpr_we_     = tag[0];
    endtask

    // Entered and left at posedge+1.
    task automatic run_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input int tag);
        string nm;
        nm = $sformatf("op%0d_tag%0d", op, tag);
        drive(op, a, b, tag);
        #1;
        check({nm, "_busy"}, 32'(ex_busy), 32'd0);
        @(posedge clk);
        #1;
        check({nm, "_out"}, ex_out, exp);
        check({nm, "_en"}, 32'(ex_en), 32'd1);
        check({nm, "_dst"}, 32'(ex_dst_addr), 32'(tag % 32));
        check({nm, "_we"}, 32'(ex_gpr_we_), 32'(tag % 2));
        check({nm, "_memop"}, 32'(ex_mem_op), 32'(tag % 4));
        check({nm, "_wdata"}, ex_mem_wr_data, 32'(tag * 3));
    endtask

    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int tag, input int stall_at,
                          input int stall_len, input int exp_edges);
        string nm;
        int    edges;
        int    busy_n;
        int    bub;
        bit    got;
        nm     = $sformatf("md_op%0d_tag%0d", op, tag);
        edges  = 0;
        busy_n = 0;
        bub    = 0;
        got    = 1'b0;
        drive(op, a, b, tag);
        for (int c = 0; c < 100 && !got; c++) begin
            stall = (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len);
            #1;
            if (ex_busy) busy_n++;
            @(posedge clk);
            #1;
            edges++;
            if (ex_en) got = 1'b1;
            else bub++;
        end
        stall = 1'b0;
        check({nm, "_arrived"}, 32'(got), 32'd1);
        check({nm, "_latency"}, 32'(edges), 32'(exp_edges));
        check({nm, "_busy_cycles"}, 32'(busy_n), 32'(exp_edges - 1));
        check({nm, "_bubbles"}, 32'(bub), 32'(exp_edges - 1));
        check({nm, "_out"}, ex_out, exp);
        check({nm, "_dst"}, 32'(ex_dst_addr), 32'(tag % 32));
        check({nm, "_we"}, 32'(ex_gpr_we_), 32'(tag % 2));
    endtask

    task automatic check_bubble(input string nm);
        check({nm, "_en"}, 32'(ex_en), 32'd0);
        check({nm, "_out"}, ex_out, 32'd0);
        check({nm, "_we"}, 32'(ex_gpr_we_), 32'd1);
        check({nm, "_memop"}, 32'(ex_mem_op), 32'(MEM_OP_NOP));
        check({nm, "_dst"}, 32'(ex_dst_addr), 32'd0);
        check({nm, "_wdata"}, ex_mem_wr_data, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{ALU_OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[1]  = '{ALU_OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[2]  = '{ALU_OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[3]  = '{ALU_OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
        vecs[4]  = '{ALU_OP_XOR,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555};
        vecs[5]  = '{ALU_OP_SLL,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000};
        vecs[6]  = '{ALU_OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vecs[7]  = '{ALU_OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[8]  = '{ALU_OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[9]  = '{ALU_OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{ALU_OP_NOP,  32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[11] = '{ALU_OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[12] = '{ALU_OP_MUL,  32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        vecs[13] = '{ALU_OP_MUL,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
        vecs[14] = '{ALU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[15] = '{ALU_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[16] = '{ALU_OP_DIVU, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[17] = '{ALU_OP_REMU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007};
        vecs[18] = '{ALU_OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[19] = '{ALU_OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[20] = '{ALU_OP_DIV,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[21] = '{ALU_OP_DIVU, 32'hFFFF_FFFF, 32'h0000_000A, 32'h1999_9999};
        vecs[22] = '{ALU_OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};

        reset          = 1'b1;
        stall          = 1'b0;
        flush          = 1'b0;
        id_en          = 1'b0;
        id_alu_op      = ALU_OP_NOP;
        id_alu_in_0    = '0;
        id_alu_in_1    = '0;
        id_mem_op      = '0;
        id_mem_wr_data = '0;
        id_dst_addr    = '0;
        id_gpr_we_     = 1'b1;

        #2;
        check_bubble("reset");
        check("reset_busy", 32'(ex_busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            if (is_md_op(vecs[i].op))
                run_md(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, i + 1, 0, 0, 34);
            else
                run_single(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, i + 1);
        end

        // Stall for 5 cycles in the middle of RUN: same result, 5 cycles later.
        run_md(ALU_OP_DIVU, 32'd100, 32'd7, 32'd14, 9, 10, 5, 39);

        // Flush in RUN cycle 10: bubble and IDLE right after the edge.
        drive(ALU_OP_DIV, 32'd100, 32'd7, 6);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        id_en = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_bubble("flush");
        check("flush_idle_busy", 32'(ex_busy), 32'd0);
        @(posedge clk);
        #1;
        check("flush_idle_busy2", 32'(ex_busy), 32'd0);
        run_md(ALU_OP_REMU, 32'd100, 32'd7, 32'd2, 7, 0, 0, 34);

        // Stall alone holds a valid result.
        run_single(ALU_OP_ADD, 32'd1, 32'd2, 32'd3, 5);
        drive(ALU_OP_ADD, 32'd10, 32'd10, 8);
        stall = 1'b1;
        @(posedge clk);
        #1;
        check("stall_hold_out", ex_out, 32'd3);
        check("stall_hold_en", 32'(ex_en), 32'd1);
        // Flush wins over stall.
        flush = 1'b1;
        @(posedge clk);
        #1;
        stall = 1'b0;
        flush = 1'b0;
        check_bubble("stall_flush");

        // Asynchronous reset mid-RUN, sampled between clock edges.
        run_single(ALU_OP_ADD, 32'd4, 32'd5, 32'd9, 3);
        drive(ALU_OP_MUL, 32'd3, 32'd3, 4);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
        end
        #1;
        reset = 1'b1;
        id_en = 1'b0;
        #1;
        check_bubble("async_reset");
        check("async_reset_busy", 32'(ex_busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_md(ALU_OP_MUL, 32'd3, 32'd3, 32'd9, 4, 0, 0, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
